// File: rtl/mac_arb_pkg.sv
// Shared types and default sizing for the MAC arbiter and its round-robin picker.
package mac_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WA      = 12;
  localparam int DEF_WB      = 8;
  localparam int DEF_WO      = 45;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_RETURN   = 2'd3
  } mac_state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request after i_last_grant.
module rr_arbiter
  import mac_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_w(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last_grant,
  output logic [IW-1:0]    o_grant,
  output logic             o_grant_valid
);

  logic [IW-1:0] w_cand;

  // Walk candidates (last+1 .. last+N_REQ) mod N_REQ; the first hit wins.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    w_cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(i_last_grant) + k) % N_REQ);
      if (!o_grant_valid && i_req[w_cand]) begin
        o_grant       = w_cand;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// Shares one fixed_mac among N_REQ requesters. One requester owns the MAC for
// a whole vector: its beats are streamed through, the single result is
// captured (or a timeout error synthesised) and handed back before the next
// round-robin grant.
//
// Handshakes: every channel uses valid/ready. A beat or result moves on a
// rising edge where both valid and ready are high; valid never depends on
// ready from the same channel, and data is held while valid waits for ready.
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int WA      = DEF_WA,
  parameter  int WB      = DEF_WB,
  parameter  int WO      = DEF_WO,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = idx_w(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*WA-1:0] req_a,
  input  logic [N_REQ*WB-1:0] req_b,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ-1:0]    req_sat,
  output logic [WA-1:0]       mac_A_data,
  output logic                mac_A_valid,
  output logic                mac_A_last,
  input  logic                mac_A_ready,
  output logic [WB-1:0]       mac_B_data,
  output logic                mac_B_valid,
  output logic                mac_B_last,
  input  logic                mac_B_ready,
  output logic                mac_OF_saturation,
  output logic                mac_UF_saturation,
  input  logic [WO-1:0]       mac_out_data,
  input  logic                mac_out_valid,
  input  logic                mac_overflow,
  input  logic                mac_underflow,
  output logic                mac_out_ready,
  output logic [WO-1:0]       res_data,
  output logic [N_REQ-1:0]    res_valid,
  input  logic [N_REQ-1:0]    res_ready,
  output logic                res_overflow,
  output logic                res_underflow,
  output logic                res_error,
  output logic [IW-1:0]       grant_id,
  output logic                busy,
  output logic [1:0]          o_dbg_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  mac_state_t    r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_last_grant;
  logic          r_sat;
  logic [CW-1:0] r_cnt;
  logic [WO-1:0] r_res_data;
  logic          r_res_ovf;
  logic          r_res_unf;
  logic          r_res_err;

  logic [IW-1:0] w_arb_grant;
  logic          w_arb_valid;
  logic          w_mac_ready;
  logic          w_g_valid;
  logic          w_beat;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .i_req         (req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_arb_grant),
    .o_grant_valid (w_arb_valid)
  );

  assign w_mac_ready = mac_A_ready & mac_B_ready;
  assign w_g_valid   = req_valid[r_grant];
  assign w_beat      = (r_state == ST_STREAM) & w_g_valid & w_mac_ready;

  // Ownership FSM plus grant, saturation, timeout counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(N_REQ - 1);
      r_sat        <= 1'b0;
      r_cnt        <= '0;
      r_res_data   <= '0;
      r_res_ovf    <= 1'b0;
      r_res_unf    <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_grant <= w_arb_grant;
            r_sat   <= req_sat[w_arb_grant];
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_beat && req_last[r_grant]) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (mac_out_valid) begin
            r_res_data <= mac_out_data;
            r_res_ovf  <= mac_overflow;
            r_res_unf  <= mac_underflow;
            r_res_err  <= 1'b0;
            r_state    <= ST_RETURN;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            // MAC never answered: hand back an explicit error, not stale data.
            r_res_data <= '0;
            r_res_ovf  <= 1'b0;
            r_res_unf  <= 1'b0;
            r_res_err  <= 1'b1;
            r_state    <= ST_RETURN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RETURN: begin
          if (res_ready[r_grant]) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Route the granted requester to the MAC and steer the one-hot ready/valid.
  always_comb begin
    req_ready   = '0;
    res_valid   = '0;
    mac_A_valid = 1'b0;
    mac_B_valid = 1'b0;
    mac_A_data  = '0;
    mac_B_data  = '0;
    mac_A_last  = 1'b0;
    mac_B_last  = 1'b0;
    if (r_state == ST_STREAM) begin
      req_ready[r_grant] = w_mac_ready;
      mac_A_valid        = w_g_valid;
      mac_B_valid        = w_g_valid;
      mac_A_data         = req_a[r_grant*WA +: WA];
      mac_B_data         = req_b[r_grant*WB +: WB];
      mac_A_last         = req_last[r_grant];
      mac_B_last         = req_last[r_grant];
    end
    if (r_state == ST_RETURN) begin
      res_valid[r_grant] = 1'b1;
    end
  end

  assign mac_out_ready     = (r_state == ST_WAIT_RES);
  assign mac_OF_saturation = r_sat;
  assign mac_UF_saturation = r_sat;
  assign res_data          = r_res_data;
  assign res_overflow      = r_res_ovf;
  assign res_underflow     = r_res_unf;
  assign res_error         = r_res_err;
  assign grant_id          = r_grant;
  assign busy              = (r_state != ST_IDLE);
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: round-robin order, streaming with gaps and
// stalls, result return, timeout, mid-stream reset and saturation latching.
module tb_mac_arbiter;
  import mac_arb_pkg::*;

  localparam int N  = 4;
  localparam int WA = 12;
  localparam int WB = 8;
  localparam int WO = 45;
  localparam int TO = 15;
  localparam int BW = WA + WB + 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_last, req_sat;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic [WA-1:0]   mac_A_data;
  logic            mac_A_valid, mac_A_last, mac_A_ready;
  logic [WB-1:0]   mac_B_data;
  logic            mac_B_valid, mac_B_last, mac_B_ready;
  logic            mac_OF_saturation, mac_UF_saturation;
  logic [WO-1:0]   mac_out_data;
  logic            mac_out_valid, mac_overflow, mac_underflow, mac_out_ready;
  logic [WO-1:0]   res_data;
  logic [N-1:0]    res_valid, res_ready;
  logic            res_overflow, res_underflow, res_error;
  logic [1:0]      grant_id;
  logic            busy;
  logic [1:0]      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  mac_arbiter #(
    .N_REQ(N), .WA(WA), .WB(WB), .WO(WO), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_last(req_last), .req_sat(req_sat),
    .mac_A_data(mac_A_data), .mac_A_valid(mac_A_valid), .mac_A_last(mac_A_last),
    .mac_A_ready(mac_A_ready),
    .mac_B_data(mac_B_data), .mac_B_valid(mac_B_valid), .mac_B_last(mac_B_last),
    .mac_B_ready(mac_B_ready),
    .mac_OF_saturation(mac_OF_saturation), .mac_UF_saturation(mac_UF_saturation),
    .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid),
    .mac_overflow(mac_overflow), .mac_underflow(mac_underflow),
    .mac_out_ready(mac_out_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_overflow(res_overflow), .res_underflow(res_underflow), .res_error(res_error),
    .grant_id(grant_id), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                         input logic l);
    return {a, b, l, l};
  endfunction

  // Scoreboard: every beat the MAC accepts must be the next expected beat.
  always @(negedge clk) begin
    if (!reset && mac_A_valid && mac_A_ready && mac_B_valid && mac_B_ready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0)
        chk("beat_data", 64'({mac_A_data, mac_B_data, mac_A_last, mac_B_last}),
            64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input mac_state_t st, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state != st && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(dbg_state), 64'(st));
  endtask

  // Drive one vector from requester g (starting from IDLE), optional gap/stall.
  task automatic stream(input int g, input int nb, input logic [WA-1:0] a,
                        input logic [WB-1:0] b, input int inc, input int gap_at,
                        input int stall_at);
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      if (i == gap_at) begin
        req_valid[g] = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("gap_state", 64'(dbg_state), 64'(ST_STREAM));
          chk("gap_avalid", 64'(mac_A_valid), 64'(0));
        end
        @(posedge clk); #1;
      end
      req_a[g*WA +: WA] = a + WA'(i * inc);
      req_b[g*WB +: WB] = b;
      req_last[g]       = (i == nb - 1);
      req_valid[g]      = 1'b1;
      exp_q.push_back(beat(a + WA'(i * inc), b, (i == nb - 1)));
      if (i == stall_at) begin
        mac_B_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", 64'(req_ready[g]), 64'(0));
        end
        @(posedge clk); #1;
        mac_B_ready = 1'b1;
      end
      n = 0;
      @(negedge clk);
      while (!req_ready[g] && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("beat_ready", 64'(req_ready[g]), 64'(1));
      if (i == 0) chk("grant", 64'(grant_id), 64'(g));
      @(posedge clk); #1;
    end
    req_valid[g] = 1'b0;
    req_last[g]  = 1'b0;
  endtask

  // Answer from the MAC lat cycles into WAIT_RES; result must show one cycle later.
  task automatic mac_reply(input int g, input int lat, input logic [WO-1:0] d,
                           input logic ovf, input logic unf);
    wait_state(ST_WAIT_RES, "enter_wait");
    chk("out_ready_wait", 64'(mac_out_ready), 64'(1));
    repeat (lat) @(posedge clk);
    @(posedge clk); #1;
    mac_out_data  = d;
    mac_out_valid = 1'b1;
    mac_overflow  = ovf;
    mac_underflow = unf;
    @(posedge clk); #1;
    mac_out_valid = 1'b0;
    mac_out_data  = '0;
    mac_overflow  = 1'b0;
    mac_underflow = 1'b0;
    @(negedge clk);
    chk("res_valid", 64'(res_valid), 64'(1) << g);
    chk("res_data", 64'(res_data), 64'(d));
    chk("res_ovf", 64'(res_overflow), 64'(ovf));
    chk("res_unf", 64'(res_underflow), 64'(unf));
    chk("res_err", 64'(res_error), 64'(0));
    chk("out_ready_ret", 64'(mac_out_ready), 64'(0));
  endtask

  // Hold off one cycle (result must stay put), then complete the handshake.
  task automatic ret_ack(input int g, input logic [WO-1:0] d);
    @(negedge clk);
    chk("res_hold", 64'(res_data), 64'(d));
    chk("res_hold_v", 64'(res_valid), 64'(1) << g);
    @(posedge clk); #1;
    res_ready[g] = 1'b1;
    @(posedge clk); #1;
    res_ready[g] = 1'b0;
    @(negedge clk);
    chk("idle_after_ret", 64'(busy), 64'(0));
    chk("res_valid_clr", 64'(res_valid), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt, guard;
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_sat = '0; req_a = '0; req_b = '0;
    mac_A_ready = 1'b1; mac_B_ready = 1'b1;
    mac_out_data = '0; mac_out_valid = 1'b0; mac_overflow = 1'b0; mac_underflow = 1'b0;
    res_ready = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_out_ready", 64'(mac_out_ready), 64'(0));
    chk("rst_avalid", 64'(mac_A_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Round robin with everyone requesting: 0,1,2,3,0.
    req_valid = '1;
    req_last  = '1;
    for (int r = 0; r < N; r++) begin
      req_a[r*WA +: WA] = WA'(12'h100 + r);
      req_b[r*WB +: WB] = WB'(8'h10 + r);
    end
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % N;
      exp_q.push_back(beat(WA'(12'h100 + g), WB'(8'h10 + g), 1'b1));
      wait_state(ST_STREAM, "rr_stream");
      chk("rr_grant", 64'(grant_id), 64'(g));
      mac_reply(g, k, WO'(k * 3 + 5), (k % 2) != 0, (k / 2 % 2) != 0);
      if (k == 4) req_valid = '0;
      ret_ack(g, WO'(k * 3 + 5));
    end

    // Requester 1: three beats with a valid gap, then a persistent re-request.
    stream(1, 3, 12'h010, 8'h04, 0, 1, -1);
    mac_reply(1, 2, 45'h0C0, 1'b0, 1'b0);
    req_a[1*WA +: WA] = 12'h020;
    req_b[1*WB +: WB] = 8'h04;
    req_last[1]  = 1'b1;
    req_valid[1] = 1'b1;
    exp_q.push_back(beat(12'h020, 8'h04, 1'b1));
    ret_ack(1, 45'h0C0);
    @(negedge clk);
    chk("regrant_state", 64'(dbg_state), 64'(ST_STREAM));
    chk("regrant_id", 64'(grant_id), 64'(1));
    mac_reply(1, 0, 45'h1F, 1'b1, 1'b1);
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    ret_ack(1, 45'h1F);

    // Requester 2: four beats, B channel stalls for five cycles mid-vector.
    stream(2, 4, 12'h200, 8'h33, 1, -1, 2);
    mac_reply(2, 1, 45'h1_0000_0000, 1'b1, 1'b0);
    ret_ack(2, 45'h1_0000_0000);

    // Requester 3: MAC stays silent, timeout after 16 WAIT_RES cycles.
    stream(3, 1, 12'h3AB, 8'h7F, 0, -1, -1);
    wait_state(ST_WAIT_RES, "to_enter");
    mac_out_data = 45'h123;
    cnt = 0;
    guard = 0;
    while (res_valid == '0 && guard < 100) begin
      if (mac_out_ready) cnt++;
      @(negedge clk);
      guard++;
    end
    mac_out_data = '0;
    chk("to_cycles", 64'(cnt), 64'(TO + 1));
    chk("to_res_valid", 64'(res_valid), 64'(4'b1000));
    chk("to_res_err", 64'(res_error), 64'(1));
    chk("to_res_data", 64'(res_data), 64'(0));
    chk("to_res_ovf", 64'(res_overflow), 64'(0));
    ret_ack(3, '0);

    // Reset mid-STREAM of requester 2, then a full contention restart.
    req_sat     = '1;
    mac_A_ready = 1'b0;
    req_a[2*WA +: WA] = 12'h2EE;
    req_b[2*WB +: WB] = 8'h22;
    req_valid[2] = 1'b1;
    wait_state(ST_STREAM, "rst_stream");
    chk("rst_pre_grant", 64'(grant_id), 64'(2));
    chk("rst_pre_sat", 64'(mac_OF_saturation), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_grant", 64'(grant_id), 64'(0));
    chk("mid_rst_avalid", 64'(mac_A_valid), 64'(0));
    chk("mid_rst_adata", 64'(mac_A_data), 64'(0));
    chk("mid_rst_sat", 64'(mac_OF_saturation), 64'(0));
    chk("mid_rst_res_v", 64'(res_valid), 64'(0));
    req_valid   = '1;
    req_last    = '1;
    mac_A_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      req_a[r*WA +: WA] = WA'(12'h500 + r);
      req_b[r*WB +: WB] = WB'(8'h50 + r);
    end
    exp_q.push_back(beat(12'h500, 8'h50, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    wait_state(ST_STREAM, "post_rst_stream");
    chk("post_rst_grant", 64'(grant_id), 64'(0));
    mac_reply(0, 0, 45'h77, 1'b0, 1'b0);
    req_valid = '0;
    ret_ack(0, 45'h77);

    // Saturation latch: req_sat=0101 with requesters 0 and 1 (1 is next after 0).
    req_sat   = 4'b0101;
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    exp_q.push_back(beat(12'h501, 8'h51, 1'b1));
    wait_state(ST_STREAM, "sat1_stream");
    chk("sat1_grant", 64'(grant_id), 64'(1));
    chk("sat1_of", 64'(mac_OF_saturation), 64'(0));
    chk("sat1_uf", 64'(mac_UF_saturation), 64'(0));
    mac_reply(1, 0, 45'h11, 1'b0, 1'b0);
    chk("sat1_of_ret", 64'(mac_OF_saturation), 64'(0));
    req_valid[1] = 1'b0;
    exp_q.push_back(beat(12'h500, 8'h50, 1'b1));
    ret_ack(1, 45'h11);
    wait_state(ST_STREAM, "sat0_stream");
    chk("sat0_grant", 64'(grant_id), 64'(0));
    chk("sat0_of", 64'(mac_OF_saturation), 64'(1));
    chk("sat0_uf", 64'(mac_UF_saturation), 64'(1));
    mac_reply(0, 0, 45'h22, 1'b0, 1'b0);
    chk("sat0_of_ret", 64'(mac_OF_saturation), 64'(1));
    req_valid = '0;
    ret_ack(0, 45'h22);

    repeat (2) @(negedge clk);
    chk("beats_left", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one fixed_mac.
REQ-002 SHALL have parameter WA, default 12, width of operand A; WB, default 8, width of operand B; WO, default 45, width of result.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles allowed in WAIT_RES.
REQ-004 SHALL provide the following ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand beat valid.
- req_ready  out  N_REQ  per-requester beat accepted.
- req_a  in  N_REQ*WA  packed A operands; requester i at [i*WA +: WA].
- req_b  in  N_REQ*WB  packed B operands.
- req_last  in  N_REQ  final beat of the requester's vector.
- req_sat  in  N_REQ  per-requester saturation enable.
- mac_A_data/mac_A_valid/mac_A_last  out  WA/1/1  A channel to the MAC.
- mac_A_ready  in  1.
- mac_B_data/mac_B_valid/mac_B_last  out  WB/1/1  B channel to the MAC.
- mac_B_ready  in  1.
- mac_OF_saturation, mac_UF_saturation  out  1  MAC saturation configuration.
- mac_out_data  in  WO; mac_out_valid, mac_overflow, mac_underflow  in  1; mac_out_ready  out  1.
- res_data  out  WO  result returned to the granted requester.
- res_valid  out  N_REQ  one-hot result valid.
- res_ready  in  N_REQ.
- res_overflow, res_underflow, res_error  out  1  result status flags.
- grant_id  out  clog2(N_REQ)  current owner.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement the FSM IDLE->STREAM->WAIT_RES->RETURN->IDLE; there are no other transitions except reset.
REQ-006 IDLE: if any req_valid is high, SHALL select the next requester round-robin, searching from (last_grant+1) mod N_REQ, register grant_id, latch req_sat[grant] into the saturation register, and move to STREAM on the next cycle.
REQ-007 The grant SHALL be locked until RETURN completes; other requesters see req_ready=0.
REQ-008 STREAM: mac_A_valid=mac_B_valid=req_valid[g]; the mac data and last outputs SHALL mirror requester g combinationally.
REQ-009 STREAM: a beat transfers when req_valid[g] & mac_A_ready & mac_B_ready; req_ready[g] SHALL equal mac_A_ready & mac_B_ready.
REQ-010 A transferred beat with req_last[g]=1 SHALL move the FSM to WAIT_RES.
REQ-011 Deassertion of req_valid[g] mid-vector SHALL leave the FSM in STREAM with no beat transferred.
REQ-012 WAIT_RES: mac_out_ready SHALL be 1; mac_out_ready SHALL be 0 in all other states.
REQ-013 WAIT_RES: on mac_out_valid, SHALL capture mac_out_data, mac_overflow and mac_underflow into the result registers, set res_error=0, and go to RETURN.
REQ-014 WAIT_RES SHALL run a wait counter cleared on entry. When the counter reaches TIMEOUT without mac_out_valid, SHALL set res_data=0 and res_error=1 and go to RETURN.
REQ-015 RETURN: res_valid[g]=1 and all other bits 0; on res_ready[g], SHALL set last_grant=g and go to IDLE.
REQ-016 RETURN: res_data and the flags SHALL be stable until the handshake completes.
REQ-017 mac_OF_saturation and mac_UF_saturation SHALL both equal the latched saturation register, and SHALL be held from the grant through RETURN.
REQ-018 A single persistent requester SHALL be re-granted after one IDLE cycle.
REQ-019 Result latency SHALL be 1 cycle from mac_out_valid to res_valid.

Reset
REQ-020 While reset is high, SHALL force state=IDLE, last_grant=N_REQ-1 (so requester 0 is first), and the counter, grant, saturation register and result registers all to 0.
REQ-021 All outputs SHALL read 0 during reset, including assertion mid-STREAM or mid-WAIT_RES; no partial result is returned.

Structure
REQ-022 A package mac_arb_pkg SHALL hold the state enum, default widths and the TIMEOUT default.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter; it is combinational, taking request and last_grant inputs and producing a grant index and a grant-valid output.

Verification
REQ-024 All 4 requesters valid in the same cycle after reset: grants SHALL be 0,1,2,3,0 in order.
REQ-025 Requester 1 streams 3 beats (a=0x010, b=0x04), MAC returns 0x0C0: res_valid=0010, res_data=0x0C0, res_error=0.
REQ-026 mac_B_ready held low for 5 cycles mid-vector: req_ready[g]=0 for those cycles, with no beats lost or duplicated.
REQ-027 MAC never asserts mac_out_valid, TIMEOUT=15: res_error=1 and res_data=0 on the 16th WAIT_RES cycle.
REQ-028 reset pulsed during STREAM of requester 2: all outputs 0 and busy=0; next grant with all requesters valid is 0.
REQ-029 req_sat=0101, requesters 0 and 1 valid: mac_OF_saturation=1 during grant 0 and 0 during grant 1.
